// File: rtl/conv_window_sequencer_if.sv
// Bundles every non-clock, non-reset signal of the 3x3 window sequencer:
// frame control, pixel RAM read port, convolution unit port and the
// result stream. The sequencer uses the master view; whatever surrounds
// it (RAM, convolution unit, consumer) uses the slave view.
interface conv_window_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int OUT_AW = 6
);
    // Frame control
    logic              start;
    logic [71:0]       kernel_in;
    logic              busy;
    logic              done;

    // Pixel RAM read port (1-cycle read latency)
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;

    // Convolution unit port
    logic [71:0]       conv_image;
    logic [71:0]       conv_kernel;
    logic [15:0]       conv_result;

    // Result stream
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [OUT_AW-1:0] out_addr;

    modport master (
        input  start, kernel_in, pix_data, conv_result, out_ready,
        output busy, done, pix_rd_en, pix_addr, conv_image, conv_kernel,
               out_valid, out_data, out_addr
    );

    modport slave (
        output start, kernel_in, pix_data, conv_result, out_ready,
        input  busy, done, pix_rd_en, pix_addr, conv_image, conv_kernel,
               out_valid, out_data, out_addr
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks a 3x3 window over an IMG_W x IMG_H 8-bit feature map (valid
// windows only, row-major). For each window it reads the nine pixels from
// a 1-cycle-latency RAM, holds the assembled window and the frame's kernel
// steady on the convolution unit for its pipeline latency, captures the
// 16-bit result and offers it on a valid/ready stream with its linear
// output index. All outputs are registered.
module conv_window_sequencer #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int ADDR_W   = 6,
    parameter int OUT_AW   = 6,
    parameter int CONV_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_window_sequencer_if.master bus
);

    // Wait counter must reach CONV_LAT, so it needs one spare code.
    localparam int                WCW       = $clog2(CONV_LAT + 2);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_W);
    localparam logic [WCW-1:0]    WAIT_LAST = WCW'(CONV_LAT);
    localparam logic [3:0]        LAST_TAP  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [3:0]        tap;
    logic [WCW-1:0]    wait_cnt;

    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] next_row;
    logic [ADDR_W-1:0] next_col;

    // Tap k of the window anchored at (r,c) sits at row r+k/3, column
    // c+k%3; the address wraps at ADDR_W bits like the rest of the math.
    function automatic logic [ADDR_W-1:0] tap_addr(
        input logic [ADDR_W-1:0] r,
        input logic [ADDR_W-1:0] c,
        input logic [3:0]        k
    );
        logic [3:0] dr;
        logic [3:0] dc;
        dr = k / 4'd3;
        dc = k % 4'd3;
        return (r + ADDR_W'(dr)) * ROW_PITCH + c + ADDR_W'(dc);
    endfunction

    // Position of the next window in row-major order over valid anchors.
    always_comb begin
        last_col = (col == LAST_COL);
        last_row = (row == LAST_ROW);
        next_col = last_col ? '0 : col + ADDR_W'(1);
        next_row = last_col ? row + ADDR_W'(1) : row;
    end

    // Frame sequencer: fetch nine taps, drain the RAM pipeline, wait out
    // the convolution latency, then hold the result until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            row             <= '0;
            col             <= '0;
            tap             <= '0;
            wait_cnt        <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pix_rd_en   <= 1'b0;
            bus.pix_addr    <= '0;
            bus.conv_image  <= '0;
            bus.conv_kernel <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_addr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.conv_kernel <= bus.kernel_in;
                        row             <= '0;
                        col             <= '0;
                        tap             <= '0;
                        bus.busy        <= 1'b1;
                        bus.out_addr    <= '0;
                        bus.pix_rd_en   <= 1'b1;
                        bus.pix_addr    <= tap_addr('0, '0, 4'd0);
                        state           <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    // Data for the previous tap arrives this cycle.
                    if (tap != 4'd0) begin
                        bus.conv_image <= {bus.conv_image[63:0], bus.pix_data};
                    end
                    if (tap == LAST_TAP) begin
                        bus.pix_rd_en <= 1'b0;
                        state         <= S_DRAIN;
                    end else begin
                        tap          <= tap + 4'd1;
                        bus.pix_addr <= tap_addr(row, col, tap + 4'd1);
                    end
                end

                S_DRAIN: begin
                    bus.conv_image <= {bus.conv_image[63:0], bus.pix_data};
                    wait_cnt       <= '0;
                    state          <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        bus.out_data  <= bus.conv_result;
                        bus.out_valid <= 1'b1;
                        state         <= S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end

                S_WRITE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (last_col && last_row) begin
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            bus.out_addr  <= bus.out_addr + OUT_AW'(1);
                            row           <= next_row;
                            col           <= next_col;
                            tap           <= '0;
                            bus.pix_rd_en <= 1'b1;
                            bus.pix_addr  <= tap_addr(next_row, next_col, 4'd0);
                            state         <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for the 3x3 window sequencer on a 4x4 map. Provides a pixel RAM
// and a 2-stage convolution unit around the DUT. Expected results come
// either from fixed reference values or from a window-by-window
// arithmetic model of the image, queued when a frame is started and
// consumed by an independent stream monitor.
module tb_conv_window_sequencer;

    localparam int IMG_W    = 4;
    localparam int IMG_H    = 4;
    localparam int ADDR_W   = 4;
    localparam int OUT_AW   = 2;
    localparam int CONV_LAT = 2;
    localparam int OUT_W    = IMG_W - 2;
    localparam int OUT_H    = IMG_H - 2;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_window_sequencer_if #(.ADDR_W(ADDR_W), .OUT_AW(OUT_AW)) bus_if ();

    conv_window_sequencer #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .ADDR_W  (ADDR_W),
        .OUT_AW  (OUT_AW),
        .CONV_LAT(CONV_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    logic [7:0]  pix_mem [IMG_W*IMG_H];
    logic [71:0] kernel_cur;
    logic [15:0] conv_pipe [CONV_LAT];

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    int   busy_cnt  = 0;
    int   ready_mode = 0;
    bit   bp_done   = 1'b0;

    // Pixel RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus_if.pix_rd_en) bus_if.pix_data <= pix_mem[bus_if.pix_addr];
    end

    // Convolution unit: byte-wise dot product, CONV_LAT registers deep.
    always @(posedge clk) begin
        conv_pipe[0] <= dot9(bus_if.conv_image, bus_if.conv_kernel);
        for (int i = 1; i < CONV_LAT; i++) conv_pipe[i] <= conv_pipe[i-1];
    end
    assign bus_if.conv_result = conv_pipe[CONV_LAT-1];

    function automatic logic [15:0] dot9(input logic [71:0] a, input logic [71:0] b);
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s += 16'(a[71-8*k -: 8]) * 16'(b[71-8*k -: 8]);
        return s;
    endfunction

    // Reference: result of the window anchored at (r,c) straight from the map.
    function automatic int ref_window(input int r, input int c);
        int sum;
        sum = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                sum += int'(pix_mem[(r+dr)*IMG_W + c + dc]) *
                       int'(kernel_cur[71 - 8*(3*dr+dc) -: 8]);
        return sum % 65536;
    endfunction

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},        int'(bus_if.busy), 0);
        checkOutput({tag, "_done"},        int'(bus_if.done), 0);
        checkOutput({tag, "_pix_rd_en"},   int'(bus_if.pix_rd_en), 0);
        checkOutput({tag, "_pix_addr"},    int'(bus_if.pix_addr), 0);
        checkOutput({tag, "_conv_image"},  int'(|bus_if.conv_image), 0);
        checkOutput({tag, "_conv_kernel"}, int'(|bus_if.conv_kernel), 0);
        checkOutput({tag, "_out_valid"},   int'(bus_if.out_valid), 0);
        checkOutput({tag, "_out_data"},    int'(bus_if.out_data), 0);
        checkOutput({tag, "_out_addr"},    int'(bus_if.out_addr), 0);
    endtask

    // Stream monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_addr", int'(bus_if.out_addr), e.addr);
                checkOutput("out_data", int'(bus_if.out_data), e.data);
            end
        end
        if (!rst && bus_if.done) done_cnt++;
        if (!rst && bus_if.busy) busy_cnt++;
    end

    // Consumer: always ready, random, or a 5-cycle stall on output 1.
    always begin
        @(posedge clk);
        #1;
        if (ready_mode == 1) begin
            bus_if.out_ready = 1'($urandom_range(0, 1));
        end else if (ready_mode == 2 && !bp_done && bus_if.out_valid && bus_if.out_addr == OUT_AW'(1)) begin
            bus_if.out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checkOutput("bp_out_valid", int'(bus_if.out_valid), 1);
                checkOutput("bp_out_data",  int'(bus_if.out_data), 54);
                checkOutput("bp_out_addr",  int'(bus_if.out_addr), 1);
                checkOutput("bp_pix_rd_en", int'(bus_if.pix_rd_en), 0);
                @(posedge clk);
                #1;
            end
            bp_done = 1'b1;
            bus_if.out_ready = 1'b1;
        end else begin
            bus_if.out_ready = 1'b1;
        end
    end

    task automatic loadRamp();
        for (int i = 0; i < IMG_W*IMG_H; i++) pix_mem[i] = 8'(i);
        kernel_cur = {9{8'd1}};
    endtask

    task automatic pushRampExpected();
        exp_q.push_back('{0, 45});
        exp_q.push_back('{1, 54});
        exp_q.push_back('{2, 81});
        exp_q.push_back('{3, 90});
    endtask

    // Runs one full frame and checks timing, done/busy and queue drain.
    task automatic applyStimulus(input int rmode, input bit disturb, input bit use_model);
        int win0_addr [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int addrs[$];
        int lat;
        int cyc;
        ready_mode = rmode;
        bp_done    = 1'b0;
        if (use_model) begin
            for (int r = 0; r < OUT_H; r++)
                for (int c = 0; c < OUT_W; c++)
                    exp_q.push_back('{r*OUT_W + c, ref_window(r, c)});
        end
        done_cnt = 0;
        busy_cnt = 0;
        bus_if.kernel_in = kernel_cur;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        checkOutput("busy_after_start", int'(bus_if.busy), 1);
        if (bus_if.pix_rd_en) addrs.push_back(int'(bus_if.pix_addr));
        lat = 0;
        while (!bus_if.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (disturb && lat == 4) begin
                bus_if.start     = 1'b1;
                bus_if.kernel_in = {8'($urandom), 32'($urandom), 32'($urandom)};
            end
            if (disturb && lat == 5) bus_if.start = 1'b0;
            if (bus_if.pix_rd_en && addrs.size() < 9) addrs.push_back(int'(bus_if.pix_addr));
        end
        // The accept cycle itself counts as the first of the 14.
        checkOutput("first_valid_latency", lat + 1, 14);
        checkOutput("win0_read_count", addrs.size(), 9);
        for (int i = 0; i < 9 && i < addrs.size(); i++)
            checkOutput("win0_pix_addr", addrs[i], win0_addr[i]);
        if (disturb) begin
            bus_if.start     = 1'b1;
            bus_if.kernel_in = ~kernel_cur;
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
        end
        cyc = 0;
        while (!bus_if.done && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("done_seen", int'(bus_if.done), 1);
        @(posedge clk);
        #1;
        checkOutput("busy_after_done", int'(bus_if.busy), 0);
        checkOutput("done_pulses", done_cnt, 1);
        if (rmode == 0) checkOutput("busy_cycles", busy_cnt, 57);
        if (rmode == 2) checkOutput("bp_exercised", int'(bp_done), 1);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.kernel_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] ramp image, unit kernel, consumer always ready");
        loadRamp();
        pushRampExpected();
        applyStimulus(0, 1'b0, 1'b0);

        $display("[TB] 5-cycle stall on output 1");
        loadRamp();
        pushRampExpected();
        applyStimulus(2, 1'b0, 1'b0);

        $display("[TB] start and kernel_in disturbed while busy");
        loadRamp();
        pushRampExpected();
        applyStimulus(0, 1'b1, 1'b0);

        $display("[TB] reset during the wait of window 2");
        loadRamp();
        pushRampExpected();
        done_cnt = 0;
        bus_if.kernel_in = kernel_cur;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("abort");
        checkOutput("abort_outputs_taken", 4 - exp_q.size(), 2);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pushRampExpected();
        applyStimulus(0, 1'b0, 1'b0);

        $display("[TB] saturated pixels and kernel");
        for (int i = 0; i < IMG_W*IMG_H; i++) pix_mem[i] = 8'd255;
        kernel_cur = {9{8'd255}};
        for (int i = 0; i < OUT_W*OUT_H; i++) exp_q.push_back('{i, 60937});
        applyStimulus(1, 1'b0, 1'b0);

        $display("[TB] random frames against the reference model");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < IMG_W*IMG_H; i++) pix_mem[i] = 8'($urandom);
            kernel_cur = {8'($urandom), 32'($urandom), 32'($urandom)};
            applyStimulus(int'($urandom_range(0, 1)), 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
